// File: rtl/stream_int_parser_if.sv
// Handshake bundle for stream_int_parser.
//   Input stream : in_data/in_valid -> parser, in_ready <- parser
//   Result stream: out_num/out_ndig/out_term/out_empty/out_err/out_valid
//                  <- parser, out_ready -> parser
// The parser takes the slave modport. A producer/consumer (or a bench)
// takes the master modport.
interface stream_int_parser_if #(
  parameter int DIGITS = 4,
  parameter int W      = 16
);
  localparam int NW = $clog2(DIGITS + 2);

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_num;
  logic [NW-1:0] out_ndig;
  logic [7:0]    out_term;
  logic          out_empty;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_num, out_ndig, out_term, out_empty, out_err, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_num, out_ndig, out_term, out_empty, out_err, out_valid
  );
endinterface

// File: rtl/stream_int_parser.sv
// Streaming ASCII decimal field parser.
// Consumes bytes one at a time. Digits ('0'..'9') accumulate into an
// unsigned value. NUL bytes are padding and are ignored. Any other byte
// terminates the field. On termination, the value, digit count, terminator,
// empty flag and error flag are presented on the result stream. They stay
// until the consumer accepts them.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - stream_int_parser_if.slave (byte input + result output handshakes)
// Parameters:
//   DIGITS - maximum digits accepted per field before flagging an error
//   W      - result width in bits
module stream_int_parser #(
  parameter int DIGITS = 4,
  parameter int W      = 16
) (
  input logic              clk,
  input logic              rst,
  stream_int_parser_if.slave bus
);

  localparam int NW = $clog2(DIGITS + 2);
  // Four extra bits hold acc*10+9 for any W-bit acc, so overflow is exact.
  localparam int PW = W + 4;
  localparam logic [NW-1:0] NDIG_MAX = NW'(DIGITS + 1);
  localparam logic [NW-1:0] NDIG_LIM = NW'(DIGITS);
  localparam logic [PW-1:0] TEN      = PW'(10);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no digit seen yet in this field
    ACC  = 2'd1,  // at least one digit accumulated
    HOLD = 2'd2   // result pending on the output
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [NW-1:0] ndig_q, ndig_d;
  logic [7:0]    term_q, term_d;
  logic          empty_q, empty_d;
  logic          err_q, err_d;

  logic          is_digit;
  logic          is_pad;
  logic          in_xfer;
  logic          out_xfer;
  logic [3:0]    dval;
  logic [PW-1:0] prod;
  logic          val_ovf;
  logic          dig_ovf;
  logic [NW-1:0] ndig_inc;

  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign is_pad   = (bus.in_data == 8'h00);
  assign dval     = bus.in_data[3:0];  // low nibble of '0'..'9' is the value
  assign in_xfer  = bus.in_valid && (state_q != HOLD);
  assign out_xfer = bus.out_ready && (state_q == HOLD);

  assign prod     = {4'b0000, acc_q} * TEN + {{(PW-4){1'b0}}, dval};
  assign val_ovf  = |prod[PW-1:W];
  // The next digit would be digit number ndig_q+1. That exceeds DIGITS once ndig_q >= DIGITS.
  assign dig_ovf  = (ndig_q >= NDIG_LIM);
  assign ndig_inc = (ndig_q == NDIG_MAX) ? ndig_q : ndig_q + NW'(1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    term_d  = term_q;
    empty_d = empty_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (is_digit) begin
            acc_d   = W'(dval);
            ndig_d  = NW'(1);
            state_d = ACC;
          end else if (!is_pad) begin
            acc_d   = '0;
            ndig_d  = '0;
            term_d  = bus.in_data;
            empty_d = 1'b1;
            state_d = HOLD;
          end
        end
      end

      ACC: begin
        if (in_xfer) begin
          if (is_digit) begin
            ndig_d = ndig_inc;
            // Once in error, acc keeps the last in-range value. Later digits are only counted.
            if (err_q || dig_ovf || val_ovf) begin
              err_d = 1'b1;
            end else begin
              acc_d = prod[W-1:0];
            end
          end else if (!is_pad) begin
            term_d  = bus.in_data;
            empty_d = 1'b0;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_xfer) begin
          acc_d   = '0;
          ndig_d  = '0;
          empty_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ndig_q  <= '0;
      term_q  <= 8'h00;
      empty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      term_q  <= term_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_num   = acc_q;
  assign bus.out_ndig  = ndig_q;
  assign bus.out_term  = term_q;
  assign bus.out_empty = empty_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_stream_int_parser.sv
// Self-checking bench for stream_int_parser.
// Two instances share one input stream: dut4 (DIGITS=4) and dut5 (DIGITS=5), both W=16.
// A monitor collects every accepted result. Directed scenarios check them against constants.
// Random fields are checked against a reference model built from the field rules.
module tb_stream_int_parser;

  localparam int WID = 16;

  typedef struct {
    int num;
    int ndig;
    int term;
    int empty;
    int err;
  } res_t;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  int n_pass  = 0;
  int n_total = 0;

  res_t obs4[$];
  res_t obs5[$];
  res_t mon4, mon5;
  logic last_valid_at_accept;

  always #5 clk = ~clk;

  stream_int_parser_if #(.DIGITS(4), .W(WID)) bus4 ();
  stream_int_parser_if #(.DIGITS(5), .W(WID)) bus5 ();

  assign bus4.in_data   = in_data;
  assign bus4.in_valid  = in_valid;
  assign bus4.out_ready = out_ready;
  assign bus5.in_data   = in_data;
  assign bus5.in_valid  = in_valid;
  assign bus5.out_ready = out_ready;

  stream_int_parser #(.DIGITS(4), .W(WID)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  stream_int_parser #(.DIGITS(5), .W(WID)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  // Inputs change 1 time unit after posedge. Outputs are sampled at negedge.
  always @(negedge clk) begin
    if (!rst && out_ready && bus4.out_valid) begin
      mon4.num = int'(bus4.out_num); mon4.ndig = int'(bus4.out_ndig);
      mon4.term = int'(bus4.out_term); mon4.empty = int'(bus4.out_empty);
      mon4.err = int'(bus4.out_err);
      obs4.push_back(mon4);
    end
    if (!rst && out_ready && bus5.out_valid) begin
      mon5.num = int'(bus5.out_num); mon5.ndig = int'(bus5.out_ndig);
      mon5.term = int'(bus5.out_term); mon5.empty = int'(bus5.out_empty);
      mon5.err = int'(bus5.out_err);
      obs5.push_back(mon5);
    end
  end

  // Reference model for one field. Digits count toward ndig, which saturates at digits+1.
  // The value keeps the longest in-range prefix. NUL is skipped. Any other byte ends the field.
  function automatic res_t model_field(input bq_t f, input int digits);
    res_t   r;
    longint val = 0;
    int     cnt = 0;
    bit     err = 0;
    r.term = 0;
    foreach (f[i]) begin
      if (f[i] >= 8'h30 && f[i] <= 8'h39) begin
        cnt++;
        if (!err) begin
          if (cnt > digits || val * 10 + (f[i] - 8'h30) > (longint'(1) << WID) - 1) err = 1;
          else val = val * 10 + (f[i] - 8'h30);
        end
      end else if (f[i] != 8'h00) begin
        r.term = int'(f[i]);
        break;
      end
    end
    r.num   = int'(val);
    r.ndig  = (cnt > digits + 1) ? digits + 1 : cnt;
    r.empty = (cnt == 0) ? 1 : 0;
    r.err   = err ? 1 : 0;
    return r;
  endfunction

  function automatic res_t take4();
    res_t r = '{-1, -1, -1, -1, -1};
    if (obs4.size() > 0) r = obs4.pop_front();
    return r;
  endfunction

  function automatic res_t take5();
    res_t r = '{-1, -1, -1, -1, -1};
    if (obs5.size() > 0) r = obs5.pop_front();
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus4.in_ready === 1'b1) begin
        got = 1;
        last_valid_at_accept = bus4.out_valid;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL send_timeout byte=%02h in_ready never rose", b);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_obs(input int n);
    for (int c = 0; c < 400 && obs4.size() < n; c++) tick(1);
    n_total++;
    if (obs4.size() < n) $display("FAIL wait_results got %0d results want %0d", obs4.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if (bus4.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus4.in_ready); else n_pass++;
    n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus4.out_valid); else n_pass++;
    n_total++; if (bus4.out_num !== 16'd0) $display("FAIL rst_out_num got %0d want 0", bus4.out_num); else n_pass++;
    n_total++; if (bus4.out_ndig !== 3'd0) $display("FAIL rst_out_ndig got %0d want 0", bus4.out_ndig); else n_pass++;
    n_total++; if (bus4.out_term !== 8'h00) $display("FAIL rst_out_term got %02h want 00", bus4.out_term); else n_pass++;
    n_total++; if (bus4.out_empty !== 1'b0) $display("FAIL rst_out_empty got %b want 0", bus4.out_empty); else n_pass++;
    n_total++; if (bus4.out_err !== 1'b0) $display("FAIL rst_out_err got %b want 0", bus4.out_err); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    res_t r;
    obs4.delete(); obs5.delete();
    out_ready = 1'b1;
    send_str("2333,");
    n_total++; if (last_valid_at_accept !== 1'b0) $display("FAIL basic_valid_early got %b want 0", last_valid_at_accept); else n_pass++;
    @(negedge clk);
    n_total++; if (bus4.out_valid !== 1'b1) $display("FAIL basic_latency out_valid got %b want 1", bus4.out_valid); else n_pass++;
    n_total++; if (bus4.in_ready !== 1'b0) $display("FAIL basic_hold_in_ready got %b want 0", bus4.in_ready); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL basic_valid_clear got %b want 0", bus4.out_valid); else n_pass++;
    n_total++; if (bus4.in_ready !== 1'b1) $display("FAIL basic_ready_back got %b want 1", bus4.in_ready); else n_pass++;
    n_total++; if (obs4.size() !== 1) $display("FAIL basic_count got %0d want 1", obs4.size()); else n_pass++;
    r = take4();
    n_total++; if (r.num !== 2333) $display("FAIL basic_num got %0d want 2333", r.num); else n_pass++;
    n_total++; if (r.ndig !== 4) $display("FAIL basic_ndig got %0d want 4", r.ndig); else n_pass++;
    n_total++; if (r.term !== ",") $display("FAIL basic_term got %02h want 2c", r.term); else n_pass++;
    n_total++; if (r.err !== 0) $display("FAIL basic_err got %0d want 0", r.err); else n_pass++;
    n_total++; if (r.empty !== 0) $display("FAIL basic_empty got %0d want 0", r.empty); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_leading_zero();
    res_t r;
    obs4.delete(); obs5.delete();
    out_ready = 1'b1;
    send_str("0016*");
    send_byte(8'h00);
    send_str("511,");
    wait_obs(2);
    r = take4();
    n_total++; if (r.num !== 16) $display("FAIL lz_num got %0d want 16", r.num); else n_pass++;
    n_total++; if (r.ndig !== 4) $display("FAIL lz_ndig got %0d want 4", r.ndig); else n_pass++;
    n_total++; if (r.term !== "*") $display("FAIL lz_term got %02h want 2a", r.term); else n_pass++;
    r = take4();
    n_total++; if (r.num !== 511) $display("FAIL pad_num got %0d want 511", r.num); else n_pass++;
    n_total++; if (r.ndig !== 3) $display("FAIL pad_ndig got %0d want 3", r.ndig); else n_pass++;
    n_total++; if (r.empty !== 0) $display("FAIL pad_empty got %0d want 0", r.empty); else n_pass++;
  endtask

  task automatic test_empty();
    res_t r;
    obs4.delete(); obs5.delete();
    out_ready = 1'b1;
    send_str(",,");
    wait_obs(2);
    for (int k = 0; k < 2; k++) begin
      r = take4();
      n_total++; if (r.empty !== 1) $display("FAIL empty%0d_flag got %0d want 1", k, r.empty); else n_pass++;
      n_total++; if (r.num !== 0) $display("FAIL empty%0d_num got %0d want 0", k, r.num); else n_pass++;
      n_total++; if (r.ndig !== 0) $display("FAIL empty%0d_ndig got %0d want 0", k, r.ndig); else n_pass++;
      n_total++; if (r.term !== ",") $display("FAIL empty%0d_term got %02h want 2c", k, r.term); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    res_t r;
    obs4.delete(); obs5.delete();
    out_ready = 1'b1;
    send_str("99999,70000,65535,65536,");
    wait_obs(4);
    // DIGITS=4 instance
    r = take4();
    n_total++; if (r.err !== 1) $display("FAIL ovf4_99999_err got %0d want 1", r.err); else n_pass++;
    n_total++; if (r.num !== 9999) $display("FAIL ovf4_99999_num got %0d want 9999", r.num); else n_pass++;
    n_total++; if (r.ndig !== 5) $display("FAIL ovf4_99999_ndig got %0d want 5", r.ndig); else n_pass++;
    r = take4();
    n_total++; if (r.err !== 1 || r.num !== 7000) $display("FAIL ovf4_70000 got err=%0d num=%0d want err=1 num=7000", r.err, r.num); else n_pass++;
    r = take4();
    n_total++; if (r.err !== 1 || r.num !== 6553) $display("FAIL ovf4_65535 got err=%0d num=%0d want err=1 num=6553", r.err, r.num); else n_pass++;
    void'(take4());
    // DIGITS=5 instance
    n_total++; if (obs5.size() !== 4) $display("FAIL ovf5_count got %0d want 4", obs5.size()); else n_pass++;
    r = take5();
    n_total++; if (r.err !== 1 || r.num !== 9999) $display("FAIL ovf5_99999 got err=%0d num=%0d want err=1 num=9999", r.err, r.num); else n_pass++;
    r = take5();
    n_total++; if (r.err !== 1) $display("FAIL ovf5_70000_err got %0d want 1", r.err); else n_pass++;
    n_total++; if (r.num !== 7000 || r.ndig !== 5) $display("FAIL ovf5_70000 got num=%0d ndig=%0d want num=7000 ndig=5", r.num, r.ndig); else n_pass++;
    r = take5();
    n_total++; if (r.err !== 0 || r.num !== 65535) $display("FAIL ovf5_65535 got err=%0d num=%0d want err=0 num=65535", r.err, r.num); else n_pass++;
    r = take5();
    n_total++; if (r.err !== 1 || r.num !== 6553) $display("FAIL ovf5_65536 got err=%0d num=%0d want err=1 num=6553", r.err, r.num); else n_pass++;
  endtask

  task automatic test_backpressure();
    res_t r;
    obs4.delete(); obs5.delete();
    out_ready = 1'b0;
    send_str("64,");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++; if (bus4.out_valid !== 1'b1) $display("FAIL bp%0d_valid got %b want 1", c, bus4.out_valid); else n_pass++;
      n_total++; if (bus4.in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got %b want 0", c, bus4.in_ready); else n_pass++;
      n_total++; if (bus4.out_num !== 16'd64 || bus4.out_ndig !== 3'd2 || bus4.out_term !== ",")
        $display("FAIL bp%0d_stable got num=%0d ndig=%0d term=%02h want 64 2 2c", c, bus4.out_num, bus4.out_ndig, bus4.out_term);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++; if (obs4.size() !== 0) $display("FAIL bp_no_xfer got %0d results want 0", obs4.size()); else n_pass++;
    out_ready = 1'b1;
    tick(1);
    @(negedge clk);
    n_total++; if (bus4.out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", bus4.out_valid); else n_pass++;
    n_total++; if (obs4.size() !== 1) $display("FAIL bp_single_xfer got %0d results want 1", obs4.size()); else n_pass++;
    r = take4();
    n_total++; if (r.num !== 64) $display("FAIL bp_num got %0d want 64", r.num); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    res_t r;
    obs4.delete(); obs5.delete();
    out_ready = 1'b1;
    send_str("12");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send_str("7,");
    tick(4);
    n_total++; if (obs4.size() !== 1) $display("FAIL rstmid_count got %0d want 1", obs4.size()); else n_pass++;
    r = take4();
    n_total++; if (r.num !== 7 || r.ndig !== 1) $display("FAIL rstmid_result got num=%0d ndig=%0d want 7 1", r.num, r.ndig); else n_pass++;
    // Reset while a result is pending must drop it.
    out_ready = 1'b0;
    send_str("5,");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) $display("FAIL rsthold_state got valid=%b ready=%b want 0 1", bus4.out_valid, bus4.in_ready); else n_pass++;
    n_total++; if (bus4.out_num !== 16'd0) $display("FAIL rsthold_num got %0d want 0", bus4.out_num); else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    tick(3);
    n_total++; if (obs4.size() !== 0) $display("FAIL rsthold_dropped got %0d results want 0", obs4.size()); else n_pass++;
  endtask

  task automatic test_random();
    res_t exp4[$];
    res_t exp5[$];
    res_t r;
    obs4.delete(); obs5.delete();
    for (int f = 0; f < 40; f++) begin
      bq_t fld;
      logic [7:0] t;
      int nd    = $urandom_range(0, 6);
      int stall = $urandom_range(0, 2);
      for (int d = 0; d < nd; d++) begin
        if ($urandom_range(0, 3) == 0) fld.push_back(8'h00);
        fld.push_back(8'h30 + 8'($urandom_range(0, 9)));
      end
      do t = 8'($urandom_range(1, 255)); while (t >= 8'h30 && t <= 8'h39);
      fld.push_back(t);
      exp4.push_back(model_field(fld, 4));
      exp5.push_back(model_field(fld, 5));
      out_ready = (stall == 0);
      foreach (fld[i]) begin
        if ($urandom_range(0, 2) == 0) tick(1);
        send_byte(fld[i]);
      end
      if (stall != 0) tick(stall);
      out_ready = 1'b1;
      tick(1);
    end
    wait_obs(exp4.size());
    n_total++; if (obs5.size() !== exp5.size()) $display("FAIL rand5_count got %0d want %0d", obs5.size(), exp5.size()); else n_pass++;
    foreach (exp4[i]) begin
      r = take4();
      n_total++; if (r.num !== exp4[i].num) $display("FAIL rand4_%0d_num got %0d want %0d", i, r.num, exp4[i].num); else n_pass++;
      n_total++; if (r.ndig !== exp4[i].ndig) $display("FAIL rand4_%0d_ndig got %0d want %0d", i, r.ndig, exp4[i].ndig); else n_pass++;
      n_total++; if (r.term !== exp4[i].term) $display("FAIL rand4_%0d_term got %02h want %02h", i, r.term, exp4[i].term); else n_pass++;
      n_total++; if (r.empty !== exp4[i].empty || r.err !== exp4[i].err)
        $display("FAIL rand4_%0d_flags got empty=%0d err=%0d want %0d %0d", i, r.empty, r.err, exp4[i].empty, exp4[i].err);
      else n_pass++;
    end
    foreach (exp5[i]) begin
      r = take5();
      n_total++; if (r.num !== exp5[i].num || r.ndig !== exp5[i].ndig || r.err !== exp5[i].err)
        $display("FAIL rand5_%0d got num=%0d ndig=%0d err=%0d want %0d %0d %0d", i, r.num, r.ndig, r.err, exp5[i].num, exp5[i].ndig, exp5[i].err);
      else n_pass++;
    end
  endtask

  initial begin
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    last_valid_at_accept = 1'b0;
    rst       = 1'b1;
    tick(3);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_leading_zero();
    test_empty();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_int_parser.md
STREAM_INT_PARSER -- requirements
Module: stream_int_parser

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4, giving the maximum accepted decimal digits per field.
REQ-002 The module SHALL have parameter W, default 16, giving the result width in bits.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_data  input  8  ASCII byte of the input stream.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  parser accepts in_data this cycle.
REQ-008 out_num  output  W  parsed unsigned value.
REQ-009 out_ndig  output  $clog2(DIGITS+2)  count of digits consumed, saturating at DIGITS+1.
REQ-010 out_term  output  8  terminator byte that closed the field.
REQ-011 out_empty  output  1  field contained no digits.
REQ-012 out_err  output  1  digit-count or value overflow occurred.
REQ-013 out_valid  output  1  result fields are valid.
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 Byte transfer SHALL occur only when in_valid and in_ready are both high on a rising edge; result transfer SHALL occur only when out_valid and out_ready are both high.
REQ-016 Byte classes: digit = 8'h30..8'h39; pad = 8'h00; terminator = any other value.
REQ-017 The FSM SHALL have states IDLE (no digit yet), ACC (at least one digit seen) and HOLD (result pending).
REQ-018 IDLE: pad SHALL be consumed and ignored; a digit SHALL load acc = digit value, ndig = 1, and go to ACC; a terminator SHALL go to HOLD with out_empty=1, out_num=0, out_ndig=0.
REQ-019 ACC: pad SHALL be consumed and ignored; a digit SHALL set acc = acc*10 + digit, truncated to W bits, and ndig = ndig+1 (saturating); a terminator SHALL go to HOLD.
REQ-020 In ACC, the error flag SHALL be set when ndig would exceed DIGITS or when acc*10+digit exceeds 2^W-1; after that, acc SHALL hold its last in-range value and remaining digits SHALL still be consumed until a terminator.
REQ-021 Leading zeros SHALL count toward ndig ("0016" gives ndig=4, value 16).
REQ-022 The terminator SHALL be consumed and latched into out_term; out_valid SHALL rise on the cycle after the terminator transfer, giving 1-cycle latency.
REQ-023 HOLD: in_ready=0, and out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 A result transfer SHALL clear out_valid, acc, ndig and the flags, and return to IDLE, with in_ready=1 on the next cycle.
REQ-025 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; it SHALL depend only on the state and not combinationally on out_ready.
REQ-026 The acc*10 computation SHALL use at least W+4 bits internally so that overflow is detected exactly.
REQ-027 out_num, out_ndig, out_term, out_empty and out_err SHALL be registered outputs.

Reset
REQ-028 Reset SHALL have priority over all other events, including an in-flight transfer on the same edge.
REQ-029 After reset: state=IDLE, in_ready=1, out_valid=0, out_num=0, out_ndig=0, out_term=8'h00, out_empty=0, out_err=0.
REQ-030 Reset asserted mid-field or in HOLD SHALL discard the partial or pending result without emitting it.

Verification
REQ-031 The bench SHALL drive "2333," with out_ready=1 and check out_num=2333, out_ndig=4, out_term=",", out_err=0, with out_valid exactly one cycle after ",".
REQ-032 The bench SHALL drive "0016*" and check out_num=16, out_ndig=4, out_term="*"; then drive 8'h00,"511," and check out_num=511, out_ndig=3.
REQ-033 The bench SHALL drive ",," and check two results, each with out_empty=1, out_num=0, out_ndig=0.
REQ-034 With DIGITS=4 and W=16, the bench SHALL drive "99999," and check out_err=1 and out_num=9999; it SHALL also drive "70000," with DIGITS=5 and check out_err=1.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles after "64," and check that out_* stay stable with in_ready=0; on release it SHALL check a single transfer with out_num=64.
REQ-036 The bench SHALL pulse rst after "12" and then drive "7," and check that the only result is out_num=7, out_ndig=1.
